mp_calc_sequencer: RTL and testbench

Host-side initiator for the multi-precision calculator. It accepts one command at a time (opcode plus four 16-bit operands) over a valid/ready handshake and drives the calculator's operand, opcode and compute pins. It waits a fixed, opcode-dependent latency, then captures the calculator's `out`/`im` results and returns them on a valid/ready response port. It sits between the command source (testbench, UART bridge or microcode ROM) and the calculator instance.

---
 rtl/mp_calc_sequencer.sv | 142 ++++++++++++++
 tb/tb_mp_calc_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_calc_sequencer.sv
// rtl/mp_calc_sequencer.sv - single-outstanding command sequencer for the multi-precision calculator
module mp_calc_sequencer #(
    parameter int LAT_SIMPLE = 12,
    parameter int LAT_CMUL   = 48,
    parameter int LAT_CDIV   = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [15:0] cmd_c,
    input  logic [15:0] cmd_d,
    output logic [15:0] calc_A,
    output logic [15:0] calc_B,
    output logic [15:0] calc_C,
    output logic [15:0] calc_D,
    output logic [7:0]  calc_opcode,
    output logic        calc_compute,
    input  logic [15:0] calc_out,
    input  logic [15:0] calc_im,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_out,
    output logic [15:0] rsp_im,
    output logic [7:0]  rsp_opcode,
    output logic        rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       bad_opcode;

    assign accept     = cmd_valid && cmd_ready;
    assign bad_opcode = cmd_opcode > 8'd9;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = bad_opcode ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   next_state = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: next_state = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default:   next_state = S_IDLE;
        endcase
    end

    // Gating with reset keeps the strobe and the handshake quiet while reset is held.
    always_comb begin
        cmd_ready    = (state == S_IDLE) && !reset;
        calc_compute = (state == S_ISSUE) && !reset;
        rsp_valid    = (state == S_RESP);
    end

    // Operands stay registered through WAIT; the calculator re-reads them in later phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            calc_A      <= 16'h0;
            calc_B      <= 16'h0;
            calc_C      <= 16'h0;
            calc_D      <= 16'h0;
            calc_opcode <= 8'h0;
            wait_cnt    <= 8'h0;
            rsp_out     <= 16'h0;
            rsp_im      <= 16'h0;
            rsp_opcode  <= 8'h0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        calc_A      <= cmd_a;
                        calc_B      <= cmd_b;
                        calc_C      <= cmd_c;
                        calc_D      <= cmd_d;
                        calc_opcode <= cmd_opcode;
                        if (bad_opcode) begin
                            rsp_out    <= 16'h0;
                            rsp_im     <= 16'h0;
                            rsp_err    <= 1'b1;
                            rsp_opcode <= cmd_opcode;
                        end
                    end
                end
                S_ISSUE: begin
                    case (calc_opcode)
                        8'd6:    wait_cnt <= 8'(LAT_CMUL);
                        8'd7:    wait_cnt <= 8'(LAT_CDIV);
                        default: wait_cnt <= 8'(LAT_SIMPLE);
                    endcase
                end
                S_WAIT: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_CAPTURE: begin
                    rsp_out    <= calc_out;
                    rsp_im     <= calc_im;
                    rsp_err    <= 1'b0;
                    rsp_opcode <= calc_opcode;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_calc_sequencer.sv
// tb/tb_mp_calc_sequencer.sv - self-checking bench for mp_calc_sequencer with a calculator stub
module tb_mp_calc_sequencer;

    localparam int LAT_SIMPLE = 12;
    localparam int LAT_CMUL   = 48;
    localparam int LAT_CDIV   = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_a, cmd_b, cmd_c, cmd_d;
    logic [15:0] calc_A, calc_B, calc_C, calc_D;
    logic [7:0]  calc_opcode;
    logic        calc_compute;
    logic [15:0] calc_out, calc_im;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_out, rsp_im;
    logic [7:0]  rsp_opcode;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int comp_q[$];
    int dbl = 0;
    logic prev_comp = 1'b0;
    int busy = 0;

    mp_calc_sequencer #(
        .LAT_SIMPLE(LAT_SIMPLE),
        .LAT_CMUL  (LAT_CMUL),
        .LAT_CDIV  (LAT_CDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_c       (cmd_c),
        .cmd_d       (cmd_d),
        .calc_A      (calc_A),
        .calc_B      (calc_B),
        .calc_C      (calc_C),
        .calc_D      (calc_D),
        .calc_opcode (calc_opcode),
        .calc_compute(calc_compute),
        .calc_out    (calc_out),
        .calc_im     (calc_im),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_out     (rsp_out),
        .rsp_im      (rsp_im),
        .rsp_opcode  (rsp_opcode),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [7:0] op);
        if (op == 8'd6) return LAT_CMUL;
        if (op == 8'd7) return LAT_CDIV;
        return LAT_SIMPLE;
    endfunction

    // Stand-in calculator: {real, imag} for each opcode.
    function automatic logic [31:0] calc_fn(input logic [7:0] op, input logic [15:0] a, b, c, d);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'h0;
        im = a ^ c;
        case (op)
            8'd0: re = a + b;
            8'd1: re = a - b;
            8'd2: re = a * b;
            8'd3: re = a & b;
            8'd4: re = a | b;
            8'd5: re = a ^ b;
            8'd6: begin re = a * c - b * d; im = a * d + b * c; end
            8'd7: begin re = a * c + b * d; im = b * c - a * d; end
            8'd8: re = ~a;
            8'd9: re = b >> 1;
            default: re = 16'h0;
        endcase
        return {re, im};
    endfunction

    // Stub drives junk while busy, then the result of whatever operands are on its pins.
    always @(posedge clk) begin
        if (reset) busy <= 0;
        else if (calc_compute) busy <= lat_of(calc_opcode) / 2;
        else if (busy != 0) busy <= busy - 1;
    end

    always_comb begin
        {calc_out, calc_im} = calc_fn(calc_opcode, calc_A, calc_B, calc_C, calc_D);
        if (busy != 0) begin
            calc_out = 16'hDEAD;
            calc_im  = 16'hBEEF;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (calc_compute) comp_q.push_back(cyc);
        if (calc_compute && prev_comp) dbl <= dbl + 1;
        prev_comp <= calc_compute;
    end

    task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, b, c, d, output int t_acc);
        int guard;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_opcode = op;
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
        while (!cmd_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (!cmd_ready) begin
            n_err++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, guard);
        end
        @(negedge clk);
        t_acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [7:0] op, input logic [15:0] a, b, c, d,
                           input int hold);
        logic [31:0] r;
        logic        exp_err;
        logic [15:0] eo, ei;
        int          exp_lat, exp_pulses, t_acc, n0, guard;
        exp_err    = op > 8'd9;
        r          = calc_fn(op, a, b, c, d);
        eo         = exp_err ? 16'h0 : r[31:16];
        ei         = exp_err ? 16'h0 : r[15:0];
        exp_lat    = exp_err ? 0 : lat_of(op) + 3;
        exp_pulses = exp_err ? 0 : 1;
        n0 = comp_q.size();
        send_cmd(op, a, b, c, d, t_acc);
        guard = 0;
        while (!rsp_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (!rsp_valid) begin
            n_err++;
            $display("FAIL %s rsp_timeout: rsp_valid=0 after %0d cycles, required 1", name, guard);
        end else begin
            n_cmp++;
            if (cyc - t_acc !== exp_lat) begin
                n_err++;
                $display("FAIL %s latency: got %0d edges after accept, required %0d", name, cyc - t_acc, exp_lat);
            end
            n_cmp++;
            if ({rsp_out, rsp_im, rsp_err, rsp_opcode} !== {eo, ei, exp_err, op}) begin
                n_err++;
                $display("FAIL %s rsp_fields: got out=%h im=%h err=%0b op=%h, required out=%h im=%h err=%0b op=%h",
                         name, rsp_out, rsp_im, rsp_err, rsp_opcode, eo, ei, exp_err, op);
            end
            n_cmp++;
            if (comp_q.size() - n0 !== exp_pulses) begin
                n_err++;
                $display("FAIL %s compute_pulses: got %0d, required %0d", name, comp_q.size() - n0, exp_pulses);
            end else if (exp_pulses == 1) begin
                n_cmp++;
                if (comp_q[comp_q.size() - 1] !== t_acc) begin
                    n_err++;
                    $display("FAIL %s compute_cycle: pulse in cycle after edge %0d, required after edge %0d",
                             name, comp_q[comp_q.size() - 1], t_acc);
                end
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, cmd_ready, rsp_out, rsp_im, rsp_err, rsp_opcode} !== {1'b1, 1'b0, eo, ei, exp_err, op}
                || comp_q.size() != n0 + exp_pulses) begin
                n_err++;
                $display("FAIL %s hold_stable: cycle %0d got valid=%0b ready=%0b out=%h im=%h pulses=%0d, required valid=1 ready=0 out=%h im=%h pulses=%0d",
                         name, i, rsp_valid, cmd_ready, rsp_out, rsp_im, comp_q.size() - n0, eo, ei, exp_pulses);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL %s after_accept: got rsp_valid=%0b cmd_ready=%0b, required 0 1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, calc_compute, calc_A, calc_B, calc_C, calc_D, calc_opcode,
             rsp_valid, rsp_out, rsp_im, rsp_opcode, rsp_err} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got ready=%0b comp=%0b A=%h op=%h valid=%0b out=%h im=%h rop=%h err=%0b, required all 0",
                     cmd_ready, calc_compute, calc_A, calc_opcode, rsp_valid, rsp_out, rsp_im, rsp_opcode, rsp_err);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %0b, required 1", cmd_ready);
        end
    endtask

    task automatic test_add;
        run_cmd("add", 8'd0, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_cmul;
        run_cmd("cmul", 8'd6, 16'd3, 16'd2, 16'd1, 16'd4, 0);
    endtask

    task automatic test_invalid;
        run_cmd("invalid", 8'h2A, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 0);
    endtask

    task automatic test_backpressure;
        run_cmd("backpressure", 8'd2, 16'h0102, 16'h0030, 16'h0007, 16'h0009, 20);
    endtask

    task automatic test_reset_mid_wait;
        int t_acc, n0;
        n0 = comp_q.size();
        send_cmd(8'd7, 16'h0011, 16'h0022, 16'h0033, 16'h0044, t_acc);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, calc_compute, calc_A, calc_B, calc_C, calc_D, calc_opcode,
             rsp_valid, rsp_out, rsp_im, rsp_opcode, rsp_err} !== '0) begin
            n_err++;
            $display("FAIL midwait_reset_values: got ready=%0b comp=%0b A=%h op=%h valid=%0b out=%h, required all 0",
                     cmd_ready, calc_compute, calc_A, calc_opcode, rsp_valid, rsp_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || comp_q.size() != n0 + 1) begin
                n_err++;
                $display("FAIL midwait_dropped: cycle %0d got rsp_valid=%0b pulses=%0d, required 0 1",
                         i, rsp_valid, comp_q.size() - n0);
                break;
            end
        end
        run_cmd("post_reset_sub", 8'd1, 16'h0010, 16'h0001, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ops[2];
        logic [15:0] av[2], bv[2], cv[2], dv[2];
        logic [23:0] got[$];
        logic [31:0] r;
        int          n0, ta, tb, guard;
        ops[0] = 8'd2; ops[1] = 8'd6;
        for (int k = 0; k < 2; k++) begin
            av[k] = 16'($urandom); bv[k] = 16'($urandom); cv[k] = 16'($urandom); dv[k] = 16'($urandom);
        end
        n0 = comp_q.size();
        rsp_ready = 1'b1;
        fork
            begin
                send_cmd(ops[0], av[0], bv[0], cv[0], dv[0], ta);
                send_cmd(ops[1], av[1], bv[1], cv[1], dv[1], tb);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    guard = 0;
                    while (!rsp_valid && guard < 300) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (rsp_valid) got.push_back({rsp_opcode, rsp_out});
                    @(negedge clk);
                end
            end
        join
        rsp_ready = 1'b0;
        n_cmp++;
        if (got.size() !== 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d responses, required 2", got.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                r = calc_fn(ops[k], av[k], bv[k], cv[k], dv[k]);
                n_cmp++;
                if (got[k] !== {ops[k], r[31:16]}) begin
                    n_err++;
                    $display("FAIL b2b_order: response %0d got op/out=%h, required %h", k, got[k], {ops[k], r[31:16]});
                end
            end
        end
        n_cmp++;
        if (comp_q.size() - n0 !== 2) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d, required 2", comp_q.size() - n0);
        end else begin
            n_cmp++;
            if (comp_q[n0 + 1] - comp_q[n0] < lat_of(ops[0]) + 3) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d cycles, required at least %0d",
                         comp_q[n0 + 1] - comp_q[n0], lat_of(ops[0]) + 3);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] op;
        for (int i = 0; i < 12; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(10, 255)) : 8'($urandom_range(0, 9));
            run_cmd("random", op, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_pulse_width;
        n_cmp++;
        if (dbl !== 0) begin
            n_err++;
            $display("FAIL compute_width: got %0d double-length pulses, required 0", dbl);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_opcode = 8'h0;
        cmd_a = 16'h0; cmd_b = 16'h0; cmd_c = 16'h0; cmd_d = 16'h0;
        rsp_ready = 1'b0;
        test_reset;
        test_add;
        test_cmul;
        test_invalid;
        test_backpressure;
        test_reset_mid_wait;
        test_back_to_back;
        test_random;
        test_pulse_width;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
